// File: rtl/axi_lite_master_cmd.sv
`default_nettype none
// ============================================================================
//  Module   : axi_lite_master_cmd
//  Brief    : AXI4-Lite initiator turning a valid/ready command port into
//             single-beat reads/writes, one outstanding, with counters.
//  Revision : 1.0 - initial release
// ============================================================================
module axi_lite_master_cmd #(
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int C_M_AXI_ADDR_WIDTH = 9
) (
    input  logic                              M_AXI_ACLK,
    input  logic                              M_AXI_ARESET,
    // command port
    input  logic                              cmd_valid,
    output logic                              cmd_ready,
    input  logic                              cmd_write,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     cmd_wdata,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,
    // response port
    output logic                              rsp_valid,
    input  logic                              rsp_ready,
    output logic                              rsp_write,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     rsp_rdata,
    output logic [1:0]                        rsp_resp,
    // statistics
    output logic [31:0]                       wr_count,
    output logic [31:0]                       rd_count,
    output logic [31:0]                       err_count,
    // AXI4-Lite master
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
    output logic [2:0]                        M_AXI_AWPROT,
    output logic                              M_AXI_AWVALID,
    input  logic                              M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                              M_AXI_WVALID,
    input  logic                              M_AXI_WREADY,
    input  logic [1:0]                        M_AXI_BRESP,
    input  logic                              M_AXI_BVALID,
    output logic                              M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
    output logic [2:0]                        M_AXI_ARPROT,
    output logic                              M_AXI_ARVALID,
    input  logic                              M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
    input  logic [1:0]                        M_AXI_RRESP,
    input  logic                              M_AXI_RVALID,
    output logic                              M_AXI_RREADY
);

    localparam int c_STRB_WIDTH = C_M_AXI_DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        S_IDLE         = 3'd0,
        S_WR_ADDR_DATA = 3'd1,
        S_WR_RESP      = 3'd2,
        S_RD_ADDR      = 3'd3,
        S_RD_DATA      = 3'd4,
        S_RESPOND      = 3'd5
    } state_t;

    state_t                          r_state;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   r_addr;
    logic [C_M_AXI_DATA_WIDTH-1:0]   r_wdata;
    logic [c_STRB_WIDTH-1:0]         r_wstrb;
    logic                            r_awvalid;
    logic                            r_wvalid;
    logic                            r_bready;
    logic                            r_arvalid;
    logic                            r_rready;
    logic                            r_aw_done;
    logic                            r_w_done;
    logic                            r_rsp_valid;
    logic                            r_rsp_write;
    logic [C_M_AXI_DATA_WIDTH-1:0]   r_rsp_rdata;
    logic [1:0]                      r_rsp_resp;
    logic [31:0]                     r_wr_count;
    logic [31:0]                     r_rd_count;
    logic [31:0]                     r_err_count;

    logic w_aw_hs;
    logic w_w_hs;
    logic w_aw_done_nxt;
    logic w_w_done_nxt;
    logic w_b_hs;
    logic w_r_hs;

    assign w_aw_hs       = r_awvalid & M_AXI_AWREADY;
    assign w_w_hs        = r_wvalid & M_AXI_WREADY;
    assign w_aw_done_nxt = r_aw_done | w_aw_hs;
    assign w_w_done_nxt  = r_w_done | w_w_hs;
    assign w_b_hs        = r_bready & M_AXI_BVALID;
    assign w_r_hs        = r_rready & M_AXI_RVALID;

    always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
        if (M_AXI_ARESET) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_bready    <= 1'b0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_aw_done   <= 1'b0;
            r_w_done    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_write <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_resp  <= 2'b00;
            r_wr_count  <= 32'd0;
            r_rd_count  <= 32'd0;
            r_err_count <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_addr  <= cmd_addr;
                        r_wdata <= cmd_wdata;
                        r_wstrb <= cmd_wstrb;
                        if (cmd_write) begin
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_aw_done <= 1'b0;
                            r_w_done  <= 1'b0;
                            r_state   <= S_WR_ADDR_DATA;
                        end else begin
                            r_arvalid <= 1'b1;
                            r_state   <= S_RD_ADDR;
                        end
                    end
                end
                // AW and W complete independently; B is awaited once both are done
                S_WR_ADDR_DATA: begin
                    if (w_aw_hs) begin
                        r_awvalid <= 1'b0;
                    end
                    if (w_w_hs) begin
                        r_wvalid <= 1'b0;
                    end
                    r_aw_done <= w_aw_done_nxt;
                    r_w_done  <= w_w_done_nxt;
                    if (w_aw_done_nxt && w_w_done_nxt) begin
                        r_bready <= 1'b1;
                        r_state  <= S_WR_RESP;
                    end
                end
                S_WR_RESP: begin
                    if (w_b_hs) begin
                        r_bready    <= 1'b0;
                        r_rsp_write <= 1'b1;
                        r_rsp_rdata <= '0;
                        r_rsp_resp  <= M_AXI_BRESP;
                        r_rsp_valid <= 1'b1;
                        r_wr_count  <= r_wr_count + 32'd1;
                        if (M_AXI_BRESP != 2'b00) begin
                            r_err_count <= r_err_count + 32'd1;
                        end
                        r_state <= S_RESPOND;
                    end
                end
                S_RD_ADDR: begin
                    if (M_AXI_ARREADY) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= S_RD_DATA;
                    end
                end
                S_RD_DATA: begin
                    if (w_r_hs) begin
                        r_rready    <= 1'b0;
                        r_rsp_write <= 1'b0;
                        r_rsp_rdata <= M_AXI_RDATA;
                        r_rsp_resp  <= M_AXI_RRESP;
                        r_rsp_valid <= 1'b1;
                        r_rd_count  <= r_rd_count + 32'd1;
                        if (M_AXI_RRESP != 2'b00) begin
                            r_err_count <= r_err_count + 32'd1;
                        end
                        r_state <= S_RESPOND;
                    end
                end
                S_RESPOND: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready     = (r_state == S_IDLE);

    assign rsp_valid     = r_rsp_valid;
    assign rsp_write     = r_rsp_write;
    assign rsp_rdata     = r_rsp_rdata;
    assign rsp_resp      = r_rsp_resp;
    assign wr_count      = r_wr_count;
    assign rd_count      = r_rd_count;
    assign err_count     = r_err_count;

    assign M_AXI_AWADDR  = r_addr;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_AWVALID = r_awvalid;
    assign M_AXI_WDATA   = r_wdata;
    assign M_AXI_WSTRB   = r_wstrb;
    assign M_AXI_WVALID  = r_wvalid;
    assign M_AXI_BREADY  = r_bready;
    assign M_AXI_ARADDR  = r_addr;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_ARVALID = r_arvalid;
    assign M_AXI_RREADY  = r_rready;

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_master_cmd.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axi_lite_master_cmd
//  Brief    : Table-driven bench with a delay-configurable AXI-Lite responder.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_axi_lite_master_cmd;

    localparam int c_DW = 32;
    localparam int c_AW = 9;

    logic              M_AXI_ACLK = 1'b0;
    logic              M_AXI_ARESET = 1'b1;
    logic              cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [c_AW-1:0]   cmd_addr = '0;
    logic [c_DW-1:0]   cmd_wdata = '0;
    logic [3:0]        cmd_wstrb = '0;
    logic              rsp_valid, rsp_ready = 1'b0, rsp_write;
    logic [c_DW-1:0]   rsp_rdata;
    logic [1:0]        rsp_resp;
    logic [31:0]       wr_count, rd_count, err_count;
    logic [c_AW-1:0]   M_AXI_AWADDR, M_AXI_ARADDR;
    logic [2:0]        M_AXI_AWPROT, M_AXI_ARPROT;
    logic              M_AXI_AWVALID, M_AXI_AWREADY;
    logic [c_DW-1:0]   M_AXI_WDATA, M_AXI_RDATA;
    logic [3:0]        M_AXI_WSTRB;
    logic              M_AXI_WVALID, M_AXI_WREADY;
    logic [1:0]        M_AXI_BRESP, M_AXI_RRESP;
    logic              M_AXI_BVALID, M_AXI_BREADY;
    logic              M_AXI_ARVALID, M_AXI_ARREADY;
    logic              M_AXI_RVALID, M_AXI_RREADY;

    axi_lite_master_cmd #(.C_M_AXI_DATA_WIDTH(c_DW), .C_M_AXI_ADDR_WIDTH(c_AW)) dut (
        .M_AXI_ACLK(M_AXI_ACLK), .M_AXI_ARESET(M_AXI_ARESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .wr_count(wr_count), .rd_count(rd_count), .err_count(err_count),
        .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
        .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
        .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
        .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
        .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
        .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
        .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
        .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
        .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
    );

    always #5 M_AXI_ACLK = ~M_AXI_ACLK;

    typedef struct {
        logic        write;
        logic [8:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          aw_dly, w_dly, b_dly, ar_dly, r_dly;
        logic [1:0]  resp;
        logic [31:0] exp_rdata;
        int          exp_wr, exp_rd, exp_err;
    } vec_t;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Responder configuration and state
    int          cfg_aw_dly = 0, cfg_w_dly = 0, cfg_b_dly = 0, cfg_ar_dly = 0, cfg_r_dly = 0;
    logic [1:0]  cfg_resp = 2'b00;
    int          aw_wait, w_wait, b_wait, ar_wait, r_wait, aw_hi, w_hi;
    bit          aw_hs, w_hs, ar_hs;
    logic [8:0]  hs_awaddr, hs_araddr;
    logic [31:0] hs_wdata;
    logic [3:0]  hs_wstrb;
    logic [31:0] mem [0:127];
    logic        p_awv, p_awr, p_wv, p_wr, p_bv, p_br, p_arv, p_arr, p_rv, p_rr;
    logic [8:0]  p_awaddr, p_araddr;
    logic [31:0] p_wdata;
    logic [3:0]  p_wstrb;

    // Handshakes are inferred from values held over the previous posedge.
    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 32'h0;
        aw_hi = 0; w_hi = 0;
        forever begin
            @(negedge M_AXI_ACLK);
            if (M_AXI_ARESET) begin
                M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_BVALID = 0; M_AXI_BRESP = 0;
                M_AXI_ARREADY = 0; M_AXI_RVALID = 0; M_AXI_RRESP = 0; M_AXI_RDATA = 0;
                aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
                aw_hs = 0; w_hs = 0; ar_hs = 0;
                p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0; p_bv = 0; p_br = 0;
                p_arv = 0; p_arr = 0; p_rv = 0; p_rr = 0;
                p_awaddr = 0; p_araddr = 0; p_wdata = 0; p_wstrb = 0;
            end else begin
                if (p_awv && p_awr) begin aw_hs = 1; hs_awaddr = p_awaddr; end
                if (p_wv && p_wr) begin w_hs = 1; hs_wdata = p_wdata; hs_wstrb = p_wstrb; end
                if (p_bv && p_br) begin M_AXI_BVALID = 0; aw_hs = 0; w_hs = 0; b_wait = 0; end
                if (p_arv && p_arr) begin ar_hs = 1; hs_araddr = p_araddr; end
                if (p_rv && p_rr) begin M_AXI_RVALID = 0; ar_hs = 0; r_wait = 0; end

                if (p_awv && !p_awr) chk("aw_hold", {M_AXI_AWVALID, M_AXI_AWADDR}, {1'b1, p_awaddr});
                if (p_wv && !p_wr)   chk("w_hold", {M_AXI_WVALID, M_AXI_WSTRB, M_AXI_WDATA}, {1'b1, p_wstrb, p_wdata});
                if (p_arv && !p_arr) chk("ar_hold", {M_AXI_ARVALID, M_AXI_ARADDR}, {1'b1, p_araddr});
                if (p_br && !p_bv)   chk("bready_hold", M_AXI_BREADY, 1);
                if (p_rr && !p_rv)   chk("rready_hold", M_AXI_RREADY, 1);
                if (M_AXI_BREADY && !p_br) chk("bready_after_aw_w", {aw_hs, w_hs}, 2'b11);

                if (M_AXI_AWVALID) begin aw_hi++; M_AXI_AWREADY = (aw_wait >= cfg_aw_dly); aw_wait++; end
                else begin M_AXI_AWREADY = 0; aw_wait = 0; end
                if (M_AXI_WVALID) begin w_hi++; M_AXI_WREADY = (w_wait >= cfg_w_dly); w_wait++; end
                else begin M_AXI_WREADY = 0; w_wait = 0; end
                if (M_AXI_ARVALID) begin M_AXI_ARREADY = (ar_wait >= cfg_ar_dly); ar_wait++; end
                else begin M_AXI_ARREADY = 0; ar_wait = 0; end

                if (aw_hs && w_hs && !M_AXI_BVALID) begin
                    if (b_wait >= cfg_b_dly) begin
                        M_AXI_BVALID = 1; M_AXI_BRESP = cfg_resp;
                        for (int b = 0; b < 4; b++)
                            if (hs_wstrb[b]) mem[hs_awaddr[8:2]][8*b +: 8] = hs_wdata[8*b +: 8];
                    end else b_wait++;
                end
                if (ar_hs && !M_AXI_RVALID) begin
                    if (r_wait >= cfg_r_dly) begin
                        M_AXI_RVALID = 1; M_AXI_RRESP = cfg_resp; M_AXI_RDATA = mem[hs_araddr[8:2]];
                    end else r_wait++;
                end

                p_awv = M_AXI_AWVALID; p_awr = M_AXI_AWREADY; p_awaddr = M_AXI_AWADDR;
                p_wv = M_AXI_WVALID; p_wr = M_AXI_WREADY; p_wdata = M_AXI_WDATA; p_wstrb = M_AXI_WSTRB;
                p_bv = M_AXI_BVALID; p_br = M_AXI_BREADY;
                p_arv = M_AXI_ARVALID; p_arr = M_AXI_ARREADY; p_araddr = M_AXI_ARADDR;
                p_rv = M_AXI_RVALID; p_rr = M_AXI_RREADY;
            end
        end
    end

    task automatic issue(input vec_t v);
        cfg_aw_dly = v.aw_dly; cfg_w_dly = v.w_dly; cfg_b_dly = v.b_dly;
        cfg_ar_dly = v.ar_dly; cfg_r_dly = v.r_dly; cfg_resp = v.resp;
        @(negedge M_AXI_ACLK);
        aw_hi = 0; w_hi = 0;
        for (int i = 0; i < 100 && !cmd_ready; i++) @(negedge M_AXI_ACLK);
        chk("cmd_ready_wait", cmd_ready, 1);
        cmd_valid = 1; cmd_write = v.write; cmd_addr = v.addr; cmd_wdata = v.wdata; cmd_wstrb = v.wstrb;
        @(negedge M_AXI_ACLK);
        cmd_valid = 0;
        if (v.write) chk("wr_valid_latency", {M_AXI_AWVALID, M_AXI_WVALID}, 2'b11);
        else         chk("rd_valid_latency", M_AXI_ARVALID, 1);
    endtask

    task automatic finish_rsp(input vec_t v);
        for (int i = 0; i < 200 && !rsp_valid; i++) @(negedge M_AXI_ACLK);
        chk("rsp_valid_wait", rsp_valid, 1);
        chk("rsp_write", rsp_write, v.write);
        chk("rsp_rdata", rsp_rdata, v.exp_rdata);
        chk("rsp_resp", rsp_resp, v.resp);
        if (v.write) begin
            chk("awvalid_cycles", aw_hi, v.aw_dly + 1);
            chk("wvalid_cycles", w_hi, v.w_dly + 1);
        end
        chk("counters", {wr_count[15:0], rd_count[15:0], err_count[15:0]},
            {v.exp_wr[15:0], v.exp_rd[15:0], v.exp_err[15:0]});
        rsp_ready = 1;
        @(negedge M_AXI_ACLK);
        rsp_ready = 0;
        chk("rsp_valid_drop", rsp_valid, 0);
    endtask

    vec_t vecs [8];
    vec_t bp_w, bp_r, rst_rd, err_rd;

    initial begin
        //              wr    addr     wdata         strb  aw w  b  ar r  resp   exp_rdata      wr rd err
        vecs[0] = '{1'b1, 9'h004, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 0, 2'b00, 32'h00000000, 1, 0, 0};
        vecs[1] = '{1'b0, 9'h004, 32'h0,        4'h0, 0, 0, 0, 0, 3, 2'b00, 32'hDEADBEEF, 1, 1, 0};
        vecs[2] = '{1'b1, 9'h010, 32'h12345678, 4'hF, 0, 3, 0, 0, 0, 2'b00, 32'h00000000, 2, 1, 0};
        vecs[3] = '{1'b1, 9'h010, 32'hAABBCCDD, 4'h5, 2, 0, 2, 0, 0, 2'b00, 32'h00000000, 3, 1, 0};
        vecs[4] = '{1'b0, 9'h010, 32'h0,        4'h0, 0, 0, 0, 1, 0, 2'b00, 32'h12BB56DD, 3, 2, 0};
        vecs[5] = '{1'b0, 9'h004, 32'h0,        4'h0, 0, 0, 0, 0, 1, 2'b10, 32'hDEADBEEF, 3, 3, 1};
        vecs[6] = '{1'b1, 9'h1FC, 32'hCAFEF00D, 4'hF, 1, 1, 0, 0, 0, 2'b11, 32'h00000000, 4, 3, 2};
        vecs[7] = '{1'b0, 9'h1FC, 32'h0,        4'h0, 0, 0, 0, 0, 0, 2'b00, 32'hCAFEF00D, 4, 4, 2};
        bp_w    = '{1'b1, 9'h020, 32'h0BADF00D, 4'hF, 0, 0, 0, 0, 0, 2'b00, 32'h00000000, 5, 4, 2};
        bp_r    = '{1'b0, 9'h020, 32'h0,        4'h0, 0, 0, 0, 0, 0, 2'b00, 32'h0BADF00D, 5, 5, 2};
        rst_rd  = '{1'b0, 9'h004, 32'h0,        4'h0, 0, 0, 0, 50, 0, 2'b00, 32'h00000000, 0, 0, 0};
        err_rd  = '{1'b0, 9'h004, 32'h0,        4'h0, 0, 0, 0, 0, 2, 2'b10, 32'hDEADBEEF, 0, 1, 1};

        repeat (3) @(negedge M_AXI_ACLK);
        chk("reset_ctrl", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY,
                           rsp_valid, rsp_write, rsp_resp}, 0);
        chk("reset_rdata", rsp_rdata, 0);
        chk("reset_counts", {wr_count, rd_count}, 0);
        chk("reset_err", err_count, 0);
        M_AXI_ARESET = 0;
        @(negedge M_AXI_ACLK);
        chk("cmd_ready_idle", cmd_ready, 1);

        foreach (vecs[i]) begin
            issue(vecs[i]);
            finish_rsp(vecs[i]);
        end

        // Response held back while a second command waits
        issue(bp_w);
        for (int i = 0; i < 100 && !rsp_valid; i++) @(negedge M_AXI_ACLK);
        cmd_valid = 1; cmd_write = 0; cmd_addr = 9'h020; cmd_wdata = 0; cmd_wstrb = 0;
        repeat (10) begin
            @(negedge M_AXI_ACLK);
            chk("bp_cmd_ready", cmd_ready, 0);
            chk("bp_rsp_stable", {rsp_valid, rsp_write, rsp_resp, rsp_rdata}, {1'b1, 1'b1, 2'b00, 32'h0});
            chk("bp_no_issue", M_AXI_ARVALID, 0);
        end
        rsp_ready = 1;
        @(negedge M_AXI_ACLK);
        rsp_ready = 0;
        chk("bp_rsp_done", {rsp_valid, cmd_ready}, 2'b01);
        @(negedge M_AXI_ACLK);
        cmd_valid = 0;
        chk("bp_second_latency", M_AXI_ARVALID, 1);
        finish_rsp(bp_r);

        // Reset while a read address is pending
        issue(rst_rd);
        @(negedge M_AXI_ACLK);
        chk("rst_ar_pending", M_AXI_ARVALID, 1);
        #2 M_AXI_ARESET = 1;
        #1;
        chk("rst_async_ar", {M_AXI_ARVALID, M_AXI_RREADY, rsp_valid}, 0);
        chk("rst_async_counts", {wr_count, rd_count}, 0);
        chk("rst_async_err", err_count, 0);
        @(negedge M_AXI_ACLK);
        @(negedge M_AXI_ACLK);
        M_AXI_ARESET = 0;
        cfg_ar_dly = 0;
        @(negedge M_AXI_ACLK);
        chk("rst_release", {cmd_ready, M_AXI_ARVALID, rsp_valid}, 3'b100);

        issue(err_rd);
        finish_rsp(err_rd);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/axi_lite_master_cmd.md
Name: axi_lite_master_cmd

Overview:
- AXI4-Lite initiator that turns a simple valid/ready command port into single-beat AXI-Lite reads and writes.
- Drives our AXI-Lite register responders (ctrl/data register blocks) from PL logic, and is also used as the test initiator for those blocks.
- One outstanding transaction at a time.
- Returns read data and response code on a held response port, and keeps transaction/error counters.

Parameters:
C_M_AXI_DATA_WIDTH, 32, AXI data width; WSTRB width = C_M_AXI_DATA_WIDTH/8
C_M_AXI_ADDR_WIDTH, 9, AXI address width

Ports:
M_AXI_ACLK  in  1  clock; everything is synchronous to its rising edge
M_AXI_ARESET  in  1  reset, asynchronous, active-high
cmd_valid  in  1  command present
cmd_ready  out  1  block can accept a command (IDLE only)
cmd_write  in  1  1 = write, 0 = read
cmd_addr  in  ADDR  byte address
cmd_wdata  in  DATA  write data
cmd_wstrb  in  DATA/8  write strobes
rsp_valid  out  1  response available
rsp_ready  in  1  response consumed
rsp_write  out  1  response belongs to a write
rsp_rdata  out  DATA  read data (0 for writes)
rsp_resp  out  2  BRESP or RRESP
wr_count, rd_count, err_count  out  32 each  completed writes, completed reads, responses != 2'b00
M_AXI_AWADDR/AWPROT/AWVALID/AWREADY, M_AXI_WDATA/WSTRB/WVALID/WREADY, M_AXI_BRESP/BVALID/BREADY, M_AXI_ARADDR/ARPROT/ARVALID/ARREADY, M_AXI_RDATA/RRESP/RVALID/RREADY  standard AXI4-Lite master directions and widths; AWPROT = ARPROT = 3'b000

Behaviour:
- Reset: async assert; all VALID/READY outputs 0; rsp_valid 0; rsp_rdata, rsp_resp, rsp_write 0; counters 0; state IDLE.
- Reset mid-transaction abandons the transaction immediately. No response is produced.
- All AXI outputs and rsp_* are registered.
- cmd_ready = 1 only in IDLE. It is decoded from state.
- States: IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, RESPOND.
- IDLE:
  - On cmd_valid, latch addr/wdata/wstrb/write.
  - Write → WR_ADDR_DATA with AWVALID = WVALID = 1 on the next cycle.
  - Read → RD_ADDR with ARVALID = 1 on the next cycle.
  - Latency: command to first VALID = 1 cycle.
- WR_ADDR_DATA:
  - AW and W are asserted in the same cycle; our responders require W present with AW.
  - Each VALID drops independently on the cycle after its handshake (VALID & READY).
  - Track aw_done and w_done. Both handshakes may occur in the same cycle or in either order.
  - When both are done → WR_RESP with BREADY = 1.
- WR_RESP: on BVALID & BREADY, capture BRESP, set rsp_write = 1, rsp_rdata = 0, clear BREADY → RESPOND.
- RD_ADDR: ARVALID held until ARREADY. Then drop ARVALID, raise RREADY → RD_DATA.
- RD_DATA: on RVALID & RREADY, capture RDATA/RRESP, set rsp_write = 0, clear RREADY → RESPOND.
- RESPOND:
  - rsp_valid = 1, rsp_* stable until rsp_ready.
  - On rsp_valid & rsp_ready, deassert rsp_valid → IDLE.
  - No new command is accepted while a response is pending.
- AXI rules:
  - VALID never depends on READY.
  - Address, data and strobe stay stable while VALID is high.
  - A responder may hold BVALID/RVALID before our READY; the response is taken only at the handshake.
- Counters:
  - Increment in the cycle the B or R handshake completes.
  - err_count increments when resp != 2'b00.
  - All counters wrap from 0xFFFFFFFF to 0.
- No timeout: a responder that never handshakes stalls the block until reset.

Test Plan:
- Write addr 0x004 data 0xDEADBEEF wstrb 0xF, responder AWREADY = WREADY = 1 → AWVALID/WVALID high for exactly 1 cycle; rsp_write = 1, rsp_resp = 0; wr_count = 1.
- Read addr 0x004 after that write, responder returns 0xDEADBEEF after 3 wait cycles → RREADY high until RVALID; rsp_rdata = 0xDEADBEEF; rd_count = 1.
- Write with AWREADY on cycle 1 and WREADY on cycle 4 → AWVALID drops after cycle 1, WVALID held with stable data until cycle 4, BREADY rises only afterwards.
- Read returning RRESP = 2'b10 → rsp_resp = 2'b10, err_count = 1, rd_count = 1.
- rsp_ready held low for 10 cycles, cmd_valid high with a second command → cmd_ready stays 0 and rsp_* stay stable. After rsp_ready, the second command is issued with its VALID in the cycle after acceptance.
- Assert M_AXI_ARESET while ARVALID = 1 → ARVALID/RREADY go 0 asynchronously, no rsp_valid, counters 0, cmd_ready = 1 after release.
